// File: rtl/ysyx_23060184_axi_rd_slave.sv
// AXI4 read-only slave backed by a word array: one burst at a time, fixed
// AR-to-first-beat latency, FIXED/INCR/WRAP addressing with per-beat SLVERR/DECERR.
module ysyx_23060184_axi_rd_slave #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ID_WIDTH   = 4,
    parameter int          MEM_WORDS  = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 2,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic [ID_WIDTH-1:0]   rid,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  rlast
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // once rvalid is high, the beat fields stay frozen until rready accepts it.

    localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [3:0]            cnt_q;
    logic [31:0]           addr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [7:0]            beat_q;
    logic                  slverr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;

    logic                  ar_bad;
    logic [31:0]           step;
    logic [31:0]           wrap_mask;
    logic [31:0]           next_addr;
    logic [31:0]           load_addr;
    logic [31:0]           off;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic                  load_last;
    logic                  load_beat;
    logic                  done;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arvalid) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_DATA;
            S_DATA:  if (rready && rlast_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign arready = (state_q == S_IDLE);
    assign rvalid  = (state_q == S_DATA);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rid     = id_q;
    assign rlast   = rlast_q;

    // Illegal size, reserved burst type, or a WRAP length that is not a power of two.
    assign ar_bad = (arsize > 3'd2) || (arburst == 2'b11) ||
                    ((arburst == 2'b10) &&
                     !((arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15)));

    assign step      = 32'd1 << size_q;
    assign wrap_mask = ((32'(len_q) + 32'd1) << size_q) - 32'd1;

    always_comb begin
        next_addr = addr_q + step;
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: next_addr = addr_q + step;
        endcase
    end

    // The beat being loaded is the first one when leaving WAIT, otherwise the successor.
    assign load_addr = (state_q == S_WAIT) ? addr_q : next_addr;
    assign off       = load_addr - BASE_ADDR;
    assign in_range  = ({1'b0, off} < MEM_BYTES);
    assign idx       = off[IDX_W+1:2];
    assign load_last = (state_q == S_WAIT) ? (len_q == 8'd0) : ((beat_q + 8'd1) == len_q);
    assign load_beat = ((state_q == S_WAIT) && (cnt_q == 4'd0)) ||
                       ((state_q == S_DATA) && rready && !rlast_q);
    assign done      = (state_q == S_DATA) && rready && rlast_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 4'd0;
            addr_q   <= 32'd0;
            id_q     <= '0;
            len_q    <= 8'd0;
            size_q   <= 3'd0;
            burst_q  <= 2'b00;
            beat_q   <= 8'd0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && arvalid) begin
                addr_q   <= 32'(araddr);
                id_q     <= arid;
                len_q    <= arlen;
                size_q   <= arsize;
                burst_q  <= arburst;
                slverr_q <= ar_bad;
                beat_q   <= 8'd0;
                cnt_q    <= 4'(LATENCY - 1);
            end
            if ((state_q == S_WAIT) && (cnt_q != 4'd0)) cnt_q <= cnt_q - 4'd1;
            if (load_beat) begin
                if (state_q == S_DATA) begin
                    addr_q <= next_addr;
                    beat_q <= beat_q + 8'd1;
                end
                rlast_q <= load_last;
                if (slverr_q) begin
                    rresp_q <= RESP_SLVERR;
                    rdata_q <= '0;
                end else if (!in_range) begin
                    rresp_q <= RESP_DECERR;
                    rdata_q <= '0;
                end else begin
                    rresp_q <= RESP_OKAY;
                    rdata_q <= mem[idx];
                end
            end
            if (done) begin
                rdata_q <= '0;
                rresp_q <= RESP_OKAY;
                rlast_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_axi_rd_slave.sv
// Bench for the AXI read slave: table of bursts checked through an expected-beat
// queue, plus hand-written reset-abandon sequences.
module tb_ysyx_23060184_axi_rd_slave;

    localparam int          DW   = 32;
    localparam int          IW   = 4;
    localparam int          MW   = 64;
    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          EW   = DW + 2 + 1 + IW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [IW-1:0] arid;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic [IW-1:0] rid;
    logic          rvalid;
    logic          rready;
    logic          rlast;

    ysyx_23060184_axi_rd_slave #(
        .DATA_WIDTH(DW),
        .ID_WIDTH  (IW),
        .MEM_WORDS (MW),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT),
        .INIT_FILE ("")
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .arid   (arid),
        .arlen  (arlen),
        .arsize (arsize),
        .arburst(arburst),
        .rdata  (rdata),
        .rresp  (rresp),
        .rid    (rid),
        .rvalid (rvalid),
        .rready (rready),
        .rlast  (rlast)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [IW-1:0] id;
        int            mode;   // 0: rready always 1, 1: random, 2: 1,0,0,1 pattern
        logic [1:0]    resp0;  // expected response of the first beat
    } vec_t;

    vec_t vecs[14];
    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];

    function automatic logic [31:0] word_of(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // ---------------- scoreboard model ----------------
    task automatic push_expected(input vec_t v);
        logic        bad;
        logic [31:0] sz, wb, lo, a;
        logic [31:0] data;
        logic [1:0]  resp;
        bad = (v.size > 3'd2) || (v.burst == 2'b11) ||
              ((v.burst == 2'b10) && !(v.len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        sz = 32'd1 << v.size;
        wb = (32'(v.len) + 32'd1) * sz;
        for (int i = 0; i <= int'(v.len); i++) begin
            data = 32'd0;
            if (bad) begin
                resp = 2'b10;
            end else begin
                case (v.burst)
                    2'b00:   a = v.addr;
                    2'b01:   a = v.addr + 32'(i) * sz;
                    default: begin
                        lo = v.addr - (v.addr % wb);
                        a  = lo + (((v.addr - lo) + 32'(i) * sz) % wb);
                    end
                endcase
                if ((64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(4 * MW))) begin
                    resp = 2'b00;
                    data = word_of(int'((a - BASE) >> 2));
                end else begin
                    resp = 2'b11;
                end
            end
            exp_q.push_back({data, resp, (i == int'(v.len)), v.id});
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_burst(input vec_t v, input bit noise);
        int n, hs, guard, pat_i;
        bit done, held, first, r;
        logic [EW-1:0] cur, prev, exp;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        push_expected(v);
        @(negedge clk);
        check("arready_idle", 64'(arready), 64'd1);
        araddr = v.addr; arid = v.id; arlen = v.len; arsize = v.size; arburst = v.burst;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = noise;
        if (noise) begin
            araddr = $urandom; arid = IW'($urandom_range(0, 15));
            arlen = 8'($urandom_range(0, 255)); arsize = 3'd0; arburst = 2'b01;
        end
        check("arready_wait", 64'(arready), 64'd0);
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(LAT));
        hs = 0; guard = 0; pat_i = 0; done = 0; held = 0; first = 1; prev = '0;
        while (!done && guard < 100) begin
            if (!rvalid) begin
                check("rvalid_in_burst", 64'(rvalid), 64'd1);
                break;
            end
            cur = {rdata, rresp, rlast, rid};
            if (held) check("stall_hold", 64'(cur), 64'(prev));
            case (v.mode)
                0:       r = 1'b1;
                1:       r = bit'($urandom_range(0, 1));
                default: begin r = pat[pat_i % 4]; pat_i++; end
            endcase
            rready = r;
            if (r) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'd1, 64'd0);
                    exp = '0;
                end else begin
                    exp = exp_q.pop_front();
                end
                check("beat", 64'(cur), 64'(exp));
                if (first) check("resp0", 64'(rresp), 64'(v.resp0));
                first = 0;
                hs++;
                if (rlast) begin
                    done = 1;
                    arvalid = 1'b0;
                end
            end
            held = !r;
            prev = cur;
            @(negedge clk);
            guard++;
        end
        rready = 1'b0;
        arvalid = 1'b0;
        check("handshakes", 64'(hs), 64'(v.len) + 64'd1);
        check("exp_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        check("idle_after", 64'({rvalid, arready, rlast}), 64'(3'b010));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"}, 64'(arready), 64'd1);
        check({tag, "_rvalid"},  64'(rvalid),  64'd0);
        check({tag, "_rlast"},   64'(rlast),   64'd0);
        check({tag, "_rresp"},   64'(rresp),   64'd0);
        check({tag, "_rid"},     64'(rid),     64'd0);
        check({tag, "_rdata"},   64'(rdata),   64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst = 1'b1; arvalid = 1'b0; rready = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
        for (int i = 0; i < MW; i++) dut.mem[i] = word_of(i);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        vecs[0]  = '{32'h8000_0000, 8'd3,  3'd2, 2'b01, 4'd5,  0, 2'b00};
        vecs[1]  = '{32'h8000_0008, 8'd3,  3'd2, 2'b10, 4'd3,  0, 2'b00};
        vecs[2]  = '{32'h8000_0010, 8'd1,  3'd2, 2'b01, 4'd9,  2, 2'b00};
        vecs[3]  = '{32'h8000_00FC, 8'd1,  3'd2, 2'b01, 4'd2,  0, 2'b00};
        vecs[4]  = '{32'h8000_0000, 8'd2,  3'd2, 2'b11, 4'd7,  0, 2'b10};
        vecs[5]  = '{32'h8000_0020, 8'd3,  3'd2, 2'b00, 4'd1,  1, 2'b00};
        vecs[6]  = '{32'h8000_0034, 8'd7,  3'd2, 2'b10, 4'd4,  1, 2'b00};
        vecs[7]  = '{32'h8000_0042, 8'd5,  3'd1, 2'b01, 4'd8,  1, 2'b00};
        vecs[8]  = '{32'h8000_0000, 8'd2,  3'd2, 2'b10, 4'd10, 0, 2'b10};
        vecs[9]  = '{32'h8000_0000, 8'd0,  3'd3, 2'b01, 4'd11, 0, 2'b10};
        vecs[10] = '{32'h7FFF_FFFC, 8'd1,  3'd2, 2'b01, 4'd12, 0, 2'b11};
        vecs[11] = '{32'hFFFF_FFFC, 8'd1,  3'd2, 2'b01, 4'd13, 0, 2'b11};
        vecs[12] = '{32'h8000_0047, 8'd15, 3'd0, 2'b10, 4'd14, 1, 2'b00};
        vecs[13] = '{32'h8000_0006, 8'd0,  3'd2, 2'b01, 4'd15, 0, 2'b00};

        for (int k = 0; k < 14; k++) run_burst(vecs[k], (k == 6));

        // Reset on the second beat of an 8-beat burst abandons it.
        @(negedge clk);
        araddr = 32'h8000_0000; arid = 4'd6; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_burst_latency", 64'(n), 64'(LAT));
        rready = 1'b1;
        @(negedge clk);
        check("rst_burst_beat1", 64'(rdata), 64'(word_of(1)));
        rst = 1'b1;
        rready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_data");
        run_burst('{32'h8000_0080, 8'd3, 3'd2, 2'b01, 4'd3, 0, 2'b00}, 1'b0);

        // Reset in WAIT: no beat may appear afterwards.
        @(negedge clk);
        araddr = 32'h8000_0010; arid = 4'd2; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rready = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid) n++;
        end
        rready = 1'b0;
        check("rst_wait_no_beats", 64'(n), 64'd0);
        run_burst('{32'h8000_00F8, 8'd3, 3'd2, 2'b10, 4'd9, 1, 2'b00}, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
